// File: rtl/solicitudes_pkg.sv
// Shared constants and helpers for the elevator request register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package solicitudes_pkg;

    localparam int   N_PISOS_DEF = 4;
    localparam logic DIR_SUBE    = 1'b1;
    localparam logic DIR_BAJA    = 1'b0;

    // Ceiling log2, usable in parameter defaults; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector per bit: flags d=1 while the registered copy is 0.
// Latency: combinational flag against the copy taken at the previous edge.
// Backpressure: none. Ports: clk, reset (sync, active-high), d[W], flanco[W].
module detector_flanco #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] flanco
);

    logic [W-1:0] copia;
    // A bit is only armed once its input has been seen low outside reset,
    // so a button held across reset release cannot look like a fresh press.
    // The arm state samples ~d during reset so a button that was already
    // released at reset release is armed immediately.
    logic [W-1:0] armado;

    always_ff @(posedge clk) begin
        if (reset) begin
            copia  <= '0;
            armado <= ~d;
        end else begin
            copia  <= d;
            armado <= armado | ~d;
        end
    end

    assign flanco = d & ~copia & armado;

endmodule

// File: rtl/registro_solicitudes.sv
// Latched hall/cabin request register for an elevator controller.
// Latency: requests set/clear on the edge that sees the press/service; hay_* are combinational.
// Backpressure: none; every cycle's inputs are accepted.
// Ports: clk, reset; bot_sube/bot_baja/bot_cab buttons; serv/serv_piso/serv_dir service
// pulse; piso_act car floor; sol_* lamps, hay_arriba/hay_abajo, pendientes, err_piso.
// Build option: CANCELAR_CABINA_EN makes a repeated cabin press toggle the request off.
module registro_solicitudes
    import solicitudes_pkg::*;
#(
    parameter int N_PISOS = N_PISOS_DEF,
    parameter int PW      = clog2(N_PISOS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_PISOS-1:0]                bot_sube,
    input  logic [N_PISOS-1:0]                bot_baja,
    input  logic [N_PISOS-1:0]                bot_cab,
    input  logic                              serv,
    input  logic [PW-1:0]                     serv_piso,
    input  logic                              serv_dir,
    input  logic [PW-1:0]                     piso_act,
    output logic [N_PISOS-1:0]                sol_sube,
    output logic [N_PISOS-1:0]                sol_baja,
    output logic [N_PISOS-1:0]                sol_cab,
    output logic                              hay_arriba,
    output logic                              hay_abajo,
    output logic [clog2(3*N_PISOS+1)-1:0]     pendientes,
    output logic                              err_piso
);

    localparam int CW = clog2(3*N_PISOS+1);

    // No "up" call exists at the top floor and no "down" call at floor 0.
    localparam logic [N_PISOS-1:0] MASK_SUBE = {1'b0, {(N_PISOS-1){1'b1}}};
    localparam logic [N_PISOS-1:0] MASK_BAJA = {{(N_PISOS-1){1'b1}}, 1'b0};

    logic [N_PISOS-1:0] flanco_sube, flanco_baja, flanco_cab;

    detector_flanco #(.W(N_PISOS)) u_det_sube (
        .clk(clk), .reset(reset), .d(bot_sube), .flanco(flanco_sube)
    );
    detector_flanco #(.W(N_PISOS)) u_det_baja (
        .clk(clk), .reset(reset), .d(bot_baja), .flanco(flanco_baja)
    );
    detector_flanco #(.W(N_PISOS)) u_det_cab (
        .clk(clk), .reset(reset), .d(bot_cab), .flanco(flanco_cab)
    );

    logic               piso_valido;
    logic               serv_ok;
    logic [N_PISOS-1:0] uno_serv;
    logic [N_PISOS-1:0] clr_sube, clr_baja, clr_cab;
    logic [N_PISOS-1:0] sube_nxt, baja_nxt, cab_nxt;
    logic [CW-1:0]      cuenta_nxt;

    assign piso_valido = int'(serv_piso) < N_PISOS;
    assign serv_ok     = serv && piso_valido;
    assign uno_serv    = serv_ok ? (N_PISOS'(1) << serv_piso) : '0;

    // End floors have only one hall direction, so service there always clears it.
    assign clr_cab  = uno_serv;
    assign clr_sube = ((serv_dir == DIR_SUBE) || (int'(serv_piso) == 0)) ? uno_serv : '0;
    assign clr_baja = ((serv_dir == DIR_BAJA) || (int'(serv_piso) == N_PISOS-1)) ? uno_serv : '0;

    // Clear is applied last so it wins over a same-cycle press.
    assign sube_nxt = (sol_sube | flanco_sube) & ~clr_sube & MASK_SUBE;
    assign baja_nxt = (sol_baja | flanco_baja) & ~clr_baja & MASK_BAJA;
`ifdef CANCELAR_CABINA_EN
    assign cab_nxt  = (sol_cab ^ flanco_cab) & ~clr_cab;
`else
    assign cab_nxt  = (sol_cab | flanco_cab) & ~clr_cab;
`endif

    always_comb begin
        cuenta_nxt = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            cuenta_nxt = cuenta_nxt + CW'(sube_nxt[i]) + CW'(baja_nxt[i]) + CW'(cab_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sol_sube   <= '0;
            sol_baja   <= '0;
            sol_cab    <= '0;
            pendientes <= '0;
            err_piso   <= 1'b0;
        end else begin
            sol_sube   <= sube_nxt;
            sol_baja   <= baja_nxt;
            sol_cab    <= cab_nxt;
            pendientes <= cuenta_nxt;
            err_piso   <= serv && !piso_valido;
        end
    end

    // Direction hints: any lit lamp strictly above / below the car.
    always_comb begin
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        if (int'(piso_act) < N_PISOS) begin
            for (int i = 0; i < N_PISOS; i++) begin
                if (i > int'(piso_act)) begin
                    hay_arriba = hay_arriba | sol_sube[i] | sol_baja[i] | sol_cab[i];
                end
                if (i < int'(piso_act)) begin
                    hay_abajo = hay_abajo | sol_sube[i] | sol_baja[i] | sol_cab[i];
                end
            end
        end
    end

endmodule

// File: doc/registro_solicitudes.md
REGISTRO_SOLICITUDES -- requirements
Module: registro_solicitudes

Interface
REQ-001 SHALL have parameter N_PISOS, default 4, meaning number of floors served (2..16).
REQ-002 SHALL have parameter PW, default clog2(N_PISOS), meaning floor-index width.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bot_sube  input  N_PISOS  hall "up" buttons, bit i = floor i, level.
REQ-006 SHALL have port bot_baja  input  N_PISOS  hall "down" buttons, bit i = floor i, level.
REQ-007 SHALL have port bot_cab  input  N_PISOS  cabin floor buttons, level.
REQ-008 SHALL have port serv  input  1  one-cycle pulse: car serving floor serv_piso.
REQ-009 SHALL have port serv_piso  input  PW  floor being served.
REQ-010 SHALL have port serv_dir  input  1  departure direction at service, 1 = up, 0 = down.
REQ-011 SHALL have port piso_act  input  PW  current car floor.
REQ-012 SHALL have ports sol_sube, sol_baja, sol_cab  output  N_PISOS each  latched request lamps.
REQ-013 SHALL have port hay_arriba / hay_abajo  output  1 each  any request strictly above / below piso_act.
REQ-014 SHALL have port pendientes  output  clog2(3*N_PISOS+1)  count of set request bits.
REQ-015 SHALL have port err_piso  output  1  one-cycle pulse on serv with serv_piso >= N_PISOS.

Function
REQ-016 SHALL register every button vector each cycle; a request bit SHALL set on the clock edge where button = 1 and its registered copy = 0 (rising edge), visible on outputs right after that edge.
REQ-017 SHALL hold a set bit until cleared by service or reset; held buttons SHALL NOT re-set a cleared bit.
REQ-018 sol_sube[N_PISOS-1] and sol_baja[0] SHALL be constant 0; presses there ignored.
REQ-019 On serv with valid floor f SHALL clear sol_cab[f] and sol_sube[f] if serv_dir=1, else sol_baja[f], on that edge.
REQ-020 At top floor serv SHALL clear sol_baja[f]; at floor 0 sol_sube[f], regardless of serv_dir.
REQ-021 Set and clear of same bit in same cycle: clear SHALL win.
REQ-022 serv with serv_piso >= N_PISOS SHALL change no state and pulse err_piso next cycle.
REQ-023 hay_arriba/hay_abajo SHALL be combinational from registered bits and piso_act; piso_act out of range -> both 0.
REQ-024 pendientes SHALL be registered, equal to popcount of all request bits after the same edge, no wrap.

Reset
REQ-025 reset SHALL clear all request bits, button copies, pendientes and err_piso to 0; reset dominates all inputs in its cycle.
REQ-026 Buttons held through reset release SHALL NOT create requests until released and pressed again.

Configuration
REQ-027 With CANCELAR_CABINA_EN defined, a new rising edge on bot_cab[i] while sol_cab[i]=1 SHALL clear it (toggle); hall bits unaffected.
REQ-028 Without CANCELAR_CABINA_EN, a repeated press on a lit cabin bit SHALL have no effect.

Structure
REQ-029 Package solicitudes_pkg SHALL hold N_PISOS default, DIR_SUBE=1, DIR_BAJA=0 constants and clog2 function.
REQ-030 Sub-module detector_flanco (parametrised width, clk/reset, registered rising-edge detect) SHALL be instantiated three times.

Verification
REQ-031 Press bot_sube[1] one cycle -> sol_sube=0010 next edge, pendientes=1, hay_arriba=1 with piso_act=0.
REQ-032 sol_cab[2]=1, sol_baja[2]=1; serv, serv_piso=2, serv_dir=0 -> both cleared, sol_sube[2] untouched, pendientes decremented by 2.
REQ-033 bot_cab[3] rising edge same cycle as serv floor 3 -> sol_cab[3] remains 0.
REQ-034 Press bot_sube[3] and bot_baja[0] with N_PISOS=4 -> no bits set, pendientes=0.
REQ-035 serv_piso=5 with N_PISOS=4 (PW=3 build) -> no state change, err_piso pulses one cycle.
REQ-036 Hold bot_cab[1] across reset deassertion -> no request; release then press -> sol_cab[1]=1; press again -> 0 with CANCELAR_CABINA_EN, stays 1 without.
